sevenseg_scan_mux: RTL and testbench

Parametrised time-multiplexed driver for N common-anode seven-segment digits. It is the successor to the two-digit scanner.
- Scans only the digits enabled in a mask.
- Inserts a blanking guard at the start of each digit slot to suppress ghosting.
- Provides global PWM brightness and a frame-start strobe.
- Sits between the display-value logic and the board's segment/anode pins.

---
 rtl/sevenseg_scan_mux.sv | 140 ++++++++++++++
 tb/tb_sevenseg_scan_mux.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_mux.sv
// rtl/sevenseg_scan_mux.sv - time-multiplexed N-digit common-anode seven-segment scanner
// Optional per-digit blink enabled by defining SEVENSEG_BLINK_EN.
module sevenseg_scan_mux #(
    parameter int N_DIGITS     = 8,
    parameter int SLOT_CYCLES  = 16,
    parameter int BLANK_CYCLES = 1,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  sevenseg_clk,
    input  logic                  reset,
    input  logic [7*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEVENSEG_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]            segval,
    output logic [N_DIGITS-1:0]   select,
    output logic                  frame_start
);

    localparam int PH_W   = $clog2(SLOT_CYCLES);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int ON_W   = $clog2(SLOT_CYCLES + 1);
    localparam int MAX_ON = SLOT_CYCLES - BLANK_CYCLES;

    logic [PH_W-1:0]     r_phase;
    logic [IDX_W-1:0]    r_idx;
    logic [ON_W-1:0]     r_on;
    logic [6:0]          r_segval;
    logic [N_DIGITS-1:0] r_select;
    logic                r_frame_start;

    logic [ON_W-1:0]     w_on;
    logic [IDX_W-1:0]    w_low_idx;
    logic [IDX_W-1:0]    w_next_idx;
    logic                w_any_en;
    logic                w_cur_en;
    logic [6:0]          w_seg;
    logic                w_slot_end;
    logic                w_frame;
    logic                w_in_window;
    logic                w_lit;
    logic                w_blink_hide;

    // The brightness latched at phase 0 must already govern that same cycle.
    always_comb begin
        w_on = r_on;
        if (r_phase == '0) begin
            w_on = (32'(brightness) > MAX_ON) ? ON_W'(MAX_ON) : ON_W'(brightness);
        end
    end

    always_comb begin
        w_any_en   = |digit_en;
        w_low_idx  = '0;
        w_next_idx = '0;
        w_cur_en   = 1'b0;
        w_seg      = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (digit_en[i]) w_low_idx = IDX_W'(i);
        end
        w_next_idx = w_low_idx;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (digit_en[i] && (i > int'(r_idx))) w_next_idx = IDX_W'(i);
        end
        if (!w_any_en) w_next_idx = r_idx;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i == int'(r_idx)) begin
                w_cur_en = digit_en[i];
                w_seg    = seg_in[7*i +: 7];
            end
        end
    end

    assign w_slot_end  = (r_phase == PH_W'(SLOT_CYCLES - 1));
    assign w_frame     = (r_phase == '0) && w_any_en && (r_idx == w_low_idx);
    assign w_in_window = (int'(r_phase) >= BLANK_CYCLES) &&
                         (int'(r_phase) < BLANK_CYCLES + int'(w_on));
    assign w_lit       = w_cur_en && w_in_window && !w_blink_hide;

`ifdef SEVENSEG_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);

    logic [FC_W-1:0] r_frame_cnt;
    logic            r_blink_vis;
    logic            w_blink_vis;
    logic            w_cur_blink;

    // Visibility that applies to the frame starting this cycle.
    assign w_blink_vis = (w_frame && (r_frame_cnt == FC_W'(BLINK_FRAMES))) ? ~r_blink_vis
                                                                           : r_blink_vis;

    always_comb begin
        w_cur_blink = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i == int'(r_idx)) w_cur_blink = blink_mask[i];
        end
    end

    assign w_blink_hide = w_cur_blink && !w_blink_vis;

    always_ff @(posedge sevenseg_clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else if (w_frame) begin
            r_blink_vis <= w_blink_vis;
            if (r_frame_cnt == FC_W'(BLINK_FRAMES)) r_frame_cnt <= FC_W'(1);
            else                                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
    end
`else
    assign w_blink_hide = (BLINK_FRAMES < 0);
`endif

    always_ff @(posedge sevenseg_clk) begin
        if (reset) begin
            r_phase       <= '0;
            r_idx         <= '0;
            r_on          <= '0;
            r_select      <= '1;
            r_segval      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_on          <= w_on;
            r_phase       <= w_slot_end ? '0 : r_phase + PH_W'(1);
            if (w_slot_end) r_idx <= w_next_idx;
            r_select      <= w_lit ? ~(N_DIGITS'(1) << r_idx) : '1;
            r_segval      <= w_lit ? w_seg : '0;
            r_frame_start <= w_frame;
        end
    end

    assign select      = r_select;
    assign segval      = r_segval;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb/tb_sevenseg_scan_mux.sv - randomized self-checking bench for sevenseg_scan_mux
module tb_sevenseg_scan_mux;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 1;
    localparam int BW    = 3;
    localparam int BF    = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [7*N-1:0] seg_in;
    logic [N-1:0] en;
    logic [BW-1:0] br;
    logic [N-1:0] bmask;
    logic [6:0]   segval;
    logic [N-1:0] sel;
    logic         fs;

    always #5 clk = ~clk;

    sevenseg_scan_mux #(
        .N_DIGITS    (N),
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK),
        .BRIGHT_W    (BW),
        .BLINK_FRAMES(BF)
    ) dut (
        .sevenseg_clk(clk),
        .reset       (rst),
        .seg_in      (seg_in),
        .digit_en    (en),
        .brightness  (br),
`ifdef SEVENSEG_BLINK_EN
        .blink_mask  (bmask),
`endif
        .segval      (segval),
        .select      (sel),
        .frame_start (fs)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_fs  = -1;
    int last_period = -1;

    // reference model state: position within slot, digit of slot, lit length, frames seen
    int m_pos, m_dig, m_len, m_frames;
    logic [N-1:0] exp_sel;
    logic [6:0]   exp_seg;
    logic         exp_fs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int lowest_enabled(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        bit vis;
        if (rst) begin
            m_pos = 0; m_dig = 0; m_len = 0; m_frames = 0;
            exp_sel = '1; exp_seg = '0; exp_fs = 1'b0;
            return;
        end
        exp_fs = 1'b0;
        if (m_pos == 0) begin
            m_len = (int'(br) < SLOT - BLANK) ? int'(br) : SLOT - BLANK;
            if (lowest_enabled(en) == m_dig) begin
                exp_fs = 1'b1;
                m_frames++;
            end
        end
        vis = 1'b1;
`ifdef SEVENSEG_BLINK_EN
        if (m_frames > 0 && (((m_frames - 1) / BF) % 2 == 1) && bmask[m_dig]) vis = 1'b0;
`endif
        exp_sel = '1;
        exp_seg = '0;
        if (en[m_dig] && vis && m_pos >= BLANK && m_pos < BLANK + m_len) begin
            exp_sel[m_dig] = 1'b0;
            exp_seg = seg_in[m_dig*7 +: 7];
        end
        m_pos++;
        if (m_pos == SLOT) begin
            m_pos = 0;
            for (int k = 1; k <= N; k++) begin
                if (en[(m_dig + k) % N]) begin
                    m_dig = (m_dig + k) % N;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        if (fs) begin
            if (last_fs >= 0) last_period = cyc - last_fs;
            last_fs = cyc;
        end
        check("select", 32'(sel), 32'(exp_sel));
        check("segval", 32'(segval), 32'(exp_seg));
        check("frame_start", 32'(fs), 32'(exp_fs));
    endtask

    initial begin
        bit found;
        rst = 1'b1; en = '0; br = '0; seg_in = '0; bmask = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();

        en = 4'b1111; br = 3'd7;
        seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        rst = 1'b1; step(); rst = 1'b0;
        last_fs = -1; last_period = -1;
        repeat (80) step();
        check("frame_period_4dig", 32'(last_period), 32'd32);

        en = 4'b0101;
        repeat (20) step();
        last_fs = -1; last_period = -1;
        repeat (48) step();
        check("frame_period_2dig", 32'(last_period), 32'd16);

        en = 4'b1111; br = 3'd2;
        repeat (40) step();
        br = 3'd3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_pos == 3) found = 1'b1;
            else step();
        end
        check("reach_mid_slot", 32'(found), 32'd1);
        br = 3'd0;
        repeat (40) step();

        br = 3'd7;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_dig == 2 && m_pos == 4) found = 1'b1;
            else step();
        end
        check("reach_dig2_phase4", 32'(found), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        repeat (20) step();

`ifdef SEVENSEG_BLINK_EN
        bmask = 4'b0010;
        rst = 1'b1; step(); rst = 1'b0;
        repeat (6*32 + 8) step();
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            if ($urandom_range(0, 15) == 0) br = BW'($urandom);
            if ($urandom_range(0, 7) == 0)  seg_in = (7*N)'($urandom);
            if ($urandom_range(0, 31) == 0) bmask = N'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
